cmac_seq: RTL

Sequencer for the shared signed complex multiply-accumulate datapath used in QFT amplitude computation. On `start` it clears the accumulator and fetches `len` operand pairs through a valid/ready handshake. For each accepted pair it issues a multiply, then accumulates the product once the multiplier pipeline delivers it. After the last accumulate it optionally runs the magnitude (abs) step and pulses `done`. It drives only datapath enables and operand indices; the arithmetic lives in the datapath.

---
 rtl/cmac_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/cmac_seq.sv
// Sequencer for the shared signed complex multiply-accumulate datapath.
// Issues operand fetches and multiplies, tracks the multiplier pipeline, then accumulates and optionally runs ABS.
module cmac_seq #(
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             do_abs,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [LEN_W-1:0] op_addr,
  output logic             dp_clr,
  output logic             dp_mul_en,
  output logic             dp_acc_en,
  output logic             dp_abs_en,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_MUL   = 3'd2,
    S_DRAIN = 3'd3,
    S_ABS   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic               r_do_abs;
  logic [LEN_W-1:0]   r_op_addr;
  logic [MUL_LAT-1:0] r_pipe;
  logic               w_handshake;
  logic               w_last_issue;
  logic               w_drain_empty;

  assign op_ready     = (r_state == S_MUL);
  assign w_handshake  = op_valid & op_ready;
  // op_addr doubles as the issued-product count, so the last issue is at len-1.
  assign w_last_issue = w_handshake && (r_op_addr == (r_len - ONE));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_do_abs  <= 1'b0;
      r_op_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_len    <= len;
        r_do_abs <= do_abs;
      end
      if (r_state == S_CLR) begin
        r_op_addr <= '0;
      end else if (w_handshake) begin
        r_op_addr <= r_op_addr + ONE;
      end
    end
  end

  // In-flight multiply tracker: one bit per pipeline stage, cleared by reset so an abort leaves no stray accumulate.
  generate
    if (MUL_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pipe <= '0;
        else      r_pipe <= w_handshake;
      end
      assign w_drain_empty = 1'b1;
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pipe <= '0;
        else      r_pipe <= {r_pipe[MUL_LAT-2:0], w_handshake};
      end
      assign w_drain_empty = ~|r_pipe[MUL_LAT-2:0];
    end
  endgenerate

  // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLR;
      S_CLR: begin
        if (r_len == '0) w_next = r_do_abs ? S_ABS : S_DONE;
        else             w_next = S_MUL;
      end
      S_MUL:   if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_empty) w_next = r_do_abs ? S_ABS : S_DONE;
      S_ABS:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign op_addr   = r_op_addr;
  assign dp_clr    = (r_state == S_CLR);
  assign dp_mul_en = w_handshake;
  assign dp_acc_en = r_pipe[MUL_LAT-1];
  assign dp_abs_en = (r_state == S_ABS);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign state     = r_state;

endmodule
